// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS-32 pipeline stages: decoded control word layout and
// ALU operation encodings.
package mips_pipe_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam ctrl_t CTRL_NOP = 8'h00;

  function automatic logic is_load(input ctrl_t c);
    return c.mem_read;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID -> EX handshake bundle: decoded instruction payload with valid/ready on
// both the upstream (in_*) and downstream (out_*) sides.
interface id_ex_pipe_reg_if
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  ctrl_t             in_ctrl;
  logic [DATA_W-1:0] in_rd1;
  logic [DATA_W-1:0] in_rd2;
  logic [DATA_W-1:0] in_imm;
  logic [REG_AW-1:0] in_rs;
  logic [REG_AW-1:0] in_rt;
  logic [REG_AW-1:0] in_rd;

  logic              out_valid;
  logic              out_ready;
  ctrl_t             out_ctrl;
  logic [DATA_W-1:0] out_rd1;
  logic [DATA_W-1:0] out_rd2;
  logic [DATA_W-1:0] out_imm;
  logic [REG_AW-1:0] out_rs;
  logic [REG_AW-1:0] out_rt;
  logic [REG_AW-1:0] out_rd;

  modport master (
    output in_valid, in_ctrl, in_rd1, in_rd2, in_imm, in_rs, in_rt, in_rd, out_ready,
    input  in_ready, out_valid, out_ctrl, out_rd1, out_rd2, out_imm, out_rs, out_rt, out_rd
  );

  modport slave (
    input  in_valid, in_ctrl, in_rd1, in_rd2, in_imm, in_rs, in_rt, in_rd, out_ready,
    output in_ready, out_valid, out_ctrl, out_rd1, out_rd2, out_imm, out_rs, out_rt, out_rd
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: main register drives the output, skid register
// catches the one beat accepted while the output is stalled.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  input  logic         inject,
  input  logic [W-1:0] inject_data
);
  logic [W-1:0] main_p0;
  logic [W-1:0] skid_p0;
  logic         vld_p0;
  logic         skid_vld_p0;
  logic         in_fire;
  logic         out_fire;

  // in_ready depends only on registered state, never on out_ready
  assign in_ready  = !skid_vld_p0;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = vld_p0 && out_ready;
  assign out_valid = vld_p0;
  assign out_data  = main_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_p0     <= '0;
      skid_p0     <= '0;
      vld_p0      <= 1'b0;
      skid_vld_p0 <= 1'b0;
    end else if (flush) begin
      vld_p0      <= 1'b0;
      skid_vld_p0 <= 1'b0;
    end else if (inject && out_fire) begin
      main_p0 <= inject_data;
      vld_p0  <= 1'b1;
    end else if (out_fire && skid_vld_p0) begin
      main_p0     <= skid_p0;
      skid_vld_p0 <= 1'b0;
    end else if (in_fire && (!vld_p0 || out_fire)) begin
      main_p0 <= in_data;
      vld_p0  <= 1'b1;
    end else if (in_fire && vld_p0 && !out_fire) begin
      skid_p0     <= in_data;
      skid_vld_p0 <= 1'b1;
    end else if (out_fire) begin
      vld_p0 <= 1'b0;
    end
  end
endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline stage: packs the decoded instruction into a skid buffer, blocks
// load-use dependents and slips a NOP bubble in behind the load, counting bubbles.
module id_ex_pipe_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int LOAD_USE_EN = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  id_ex_pipe_reg_if.slave  bus,
  output logic [CNT_W-1:0] bubble_cnt
);
  typedef struct packed {
    ctrl_t             ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } payload_t;

  localparam int PW = $bits(payload_t);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  payload_t in_pl;
  payload_t out_pl;
  payload_t bubble_pl;
  logic     main_v;
  logic     buf_in_ready;
  logic     hazard;
  logic     inject;
  logic     out_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    in_pl.ctrl = bus.in_ctrl;
    in_pl.rd1  = bus.in_rd1;
    in_pl.rd2  = bus.in_rd2;
    in_pl.imm  = bus.in_imm;
    in_pl.rs   = bus.in_rs;
    in_pl.rt   = bus.in_rt;
    in_pl.rd   = bus.in_rd;
  end

  always_comb begin
    bubble_pl      = '0;
    bubble_pl.ctrl = CTRL_NOP;
  end

  assign hazard = (LOAD_USE_EN != 0) && bus.in_valid && main_v && is_load(out_pl.ctrl)
                  && (out_pl.rt != '0)
                  && ((out_pl.rt == bus.in_rs) || (out_pl.rt == bus.in_rt));

  // With the skid full, the beat behind the load is the skid entry, not the
  // stalled input; it must move up first or it would be overwritten by the bubble.
  assign inject   = hazard && buf_in_ready;
  assign out_fire = main_v && bus.out_ready;

  assign bus.in_ready = buf_in_ready && !hazard;

  pipe_skid_buf #(.W(PW)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (bus.in_valid && !hazard),
    .in_data     (in_pl),
    .in_ready    (buf_in_ready),
    .out_valid   (main_v),
    .out_ready   (bus.out_ready),
    .out_data    (out_pl),
    .inject      (inject),
    .inject_data (bubble_pl)
  );

  assign bus.out_valid = main_v;
  assign bus.out_ctrl  = out_pl.ctrl;
  assign bus.out_rd1   = out_pl.rd1;
  assign bus.out_rd2   = out_pl.rd2;
  assign bus.out_imm   = out_pl.imm;
  assign bus.out_rs    = out_pl.rs;
  assign bus.out_rt    = out_pl.rt;
  assign bus.out_rd    = out_pl.rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (!flush && inject && out_fire) begin
      bubble_cnt <= sat_inc(bubble_cnt);
    end
  end
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: per-cycle vector table plus hand-written
// async-reset and counter-saturation sequences (2-bit bubble counter).
module tb_id_ex_pipe_reg;
  import mips_pipe_pkg::*;

  localparam logic [7:0] C_LW   = 8'hE4;
  localparam logic [7:0] C_RT   = 8'h8A;
  localparam logic [7:0] C_ADDI = 8'h84;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [1:0] bubble_cnt;
  int         ncmp = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.DATA_W(32), .REG_AW(5)) bus ();

  id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5), .LOAD_USE_EN(1), .CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus.slave),
    .bubble_cnt (bubble_cnt)
  );

  typedef struct {
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [7:0]  ctrl;
    logic [31:0] rd1;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        x_ir;
    logic        x_ov;
    logic [7:0]  x_ctrl;
    logic [31:0] x_rd1;
    logic [4:0]  x_rs;
    logic [4:0]  x_rt;
    logic [1:0]  x_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fl, iv, ordy, input logic [7:0] c,
                              input logic [31:0] d, input logic [4:0] rs, rt,
                              input logic x_ir, x_ov, input logic [7:0] x_c,
                              input logic [31:0] x_d, input logic [4:0] x_rs, x_rt,
                              input logic [1:0] x_cnt);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ordy = ordy; v.ctrl = c; v.rd1 = d; v.rs = rs; v.rt = rt;
    v.x_ir = x_ir; v.x_ov = x_ov; v.x_ctrl = x_c; v.x_rd1 = x_d;
    v.x_rs = x_rs; v.x_rt = x_rt; v.x_cnt = x_cnt;
    return v;
  endfunction

  function automatic logic [31:0] rd2_of(input logic [31:0] d);
    return {d[15:0], d[31:16]};
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] d);
    return {d[30:0], 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, iv, ordy, input logic [7:0] c,
                       input logic [31:0] d, input logic [4:0] rs, rt);
    flush         = fl;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    bus.in_ctrl   = c;
    bus.in_rd1    = d;
    bus.in_rd2    = rd2_of(d);
    bus.in_imm    = imm_of(d);
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_rd     = d[4:0];
  endtask

  task automatic chk_payload(input string nm, input logic [7:0] c, input logic [31:0] d,
                             input logic [4:0] rs, rt);
    chk({nm, " ctrl"}, bus.out_ctrl, c);
    chk({nm, " rd1"},  bus.out_rd1, d);
    chk({nm, " rd2"},  bus.out_rd2, rd2_of(d));
    chk({nm, " imm"},  bus.out_imm, imm_of(d));
    chk({nm, " rs"},   bus.out_rs, rs);
    chk({nm, " rt"},   bus.out_rt, rt);
    chk({nm, " rd"},   bus.out_rd, d[4:0]);
  endtask

  // Apply one cycle of inputs, check in_ready before the edge, return at edge+1.
  task automatic step(input string nm, input logic fl, iv, ordy, input logic [7:0] c,
                      input logic [31:0] d, input logic [4:0] rs, rt, input logic x_ir);
    drive(fl, iv, ordy, c, d, rs, rt);
    #1;
    chk({nm, " in_ready"}, bus.in_ready, x_ir);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 5'd0, 5'd0);
    #1;
    chk("reset out_valid", bus.out_valid, 1'b0);
    chk("reset in_ready", bus.in_ready, 1'b1);
    chk("reset bubble_cnt", bubble_cnt, 2'd0);
    chk("reset out_rd1", bus.out_rd1, 32'h0);
    #21 rst_n = 1'b1;
    @(posedge clk);
    #1;

    //             fl iv or  ctrl    rd1     rs rt   ir ov x_ctrl  x_rd1   xrs xrt cnt
    vecs.push_back(mk(0, 1, 1, C_RT,   32'h0A, 1, 2,  1, 1, C_RT,   32'h0A, 1, 2, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00,  32'h00, 0, 0,  1, 0, 8'h00,  32'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_ADDI, 32'hB1, 1, 3,  1, 1, C_ADDI, 32'hB1, 1, 3, 0));
    vecs.push_back(mk(0, 1, 0, C_ADDI, 32'hB2, 1, 4,  1, 1, C_ADDI, 32'hB1, 1, 3, 0));
    vecs.push_back(mk(0, 1, 0, C_ADDI, 32'hB3, 1, 6,  0, 1, C_ADDI, 32'hB1, 1, 3, 0));
    vecs.push_back(mk(0, 1, 1, C_ADDI, 32'hB3, 1, 6,  0, 1, C_ADDI, 32'hB2, 1, 4, 0));
    vecs.push_back(mk(0, 1, 1, C_ADDI, 32'hB3, 1, 6,  1, 1, C_ADDI, 32'hB3, 1, 6, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00,  32'h00, 0, 0,  1, 0, 8'h00,  32'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_LW,   32'hC1, 1, 5,  1, 1, C_LW,   32'hC1, 1, 5, 0));
    vecs.push_back(mk(0, 1, 0, C_RT,   32'hC2, 5, 7,  0, 1, C_LW,   32'hC1, 1, 5, 0));
    vecs.push_back(mk(0, 1, 1, C_RT,   32'hC2, 5, 7,  0, 1, 8'h00,  32'h00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, C_RT,   32'hC2, 5, 7,  1, 1, C_RT,   32'hC2, 5, 7, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00,  32'h00, 0, 0,  1, 0, 8'h00,  32'h00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, C_LW,   32'hD1, 1, 0,  1, 1, C_LW,   32'hD1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, C_RT,   32'hD2, 0, 0,  1, 1, C_RT,   32'hD2, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00,  32'h00, 0, 0,  1, 0, 8'h00,  32'h00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, C_LW,   32'hE1, 2, 9,  1, 1, C_LW,   32'hE1, 2, 9, 1));
    vecs.push_back(mk(0, 1, 1, C_RT,   32'hE2, 3, 9,  0, 1, 8'h00,  32'h00, 0, 0, 2));
    vecs.push_back(mk(0, 1, 1, C_RT,   32'hE2, 3, 9,  1, 1, C_RT,   32'hE2, 3, 9, 2));
    vecs.push_back(mk(0, 0, 1, 8'h00,  32'h00, 0, 0,  1, 0, 8'h00,  32'h00, 0, 0, 2));
    vecs.push_back(mk(0, 1, 0, C_ADDI, 32'hF1, 1, 3,  1, 1, C_ADDI, 32'hF1, 1, 3, 2));
    vecs.push_back(mk(0, 1, 0, C_ADDI, 32'hF2, 1, 3,  1, 1, C_ADDI, 32'hF1, 1, 3, 2));
    vecs.push_back(mk(1, 1, 0, C_ADDI, 32'hF3, 1, 3,  0, 0, 8'h00,  32'h00, 0, 0, 2));
    vecs.push_back(mk(0, 0, 1, 8'h00,  32'h00, 0, 0,  1, 0, 8'h00,  32'h00, 0, 0, 2));
    vecs.push_back(mk(1, 1, 1, C_ADDI, 32'hF4, 1, 3,  1, 0, 8'h00,  32'h00, 0, 0, 2));
    vecs.push_back(mk(0, 0, 1, 8'h00,  32'h00, 0, 0,  1, 0, 8'h00,  32'h00, 0, 0, 2));
    vecs.push_back(mk(0, 1, 0, C_LW,   32'h61, 1, 5,  1, 1, C_LW,   32'h61, 1, 5, 2));
    vecs.push_back(mk(0, 1, 0, C_ADDI, 32'h62, 1, 8,  1, 1, C_LW,   32'h61, 1, 5, 2));
    vecs.push_back(mk(0, 1, 1, C_RT,   32'h63, 5, 1,  0, 1, C_ADDI, 32'h62, 1, 8, 2));
    vecs.push_back(mk(0, 1, 1, C_RT,   32'h63, 5, 1,  1, 1, C_RT,   32'h63, 5, 1, 2));
    vecs.push_back(mk(0, 0, 1, 8'h00,  32'h00, 0, 0,  1, 0, 8'h00,  32'h00, 0, 0, 2));

    foreach (vecs[k]) begin
      vec_t v;
      string nm;
      v  = vecs[k];
      nm = $sformatf("vec%0d", k);
      step(nm, v.fl, v.iv, v.ordy, v.ctrl, v.rd1, v.rs, v.rt, v.x_ir);
      chk({nm, " out_valid"}, bus.out_valid, v.x_ov);
      chk({nm, " bubble_cnt"}, bubble_cnt, v.x_cnt);
      if (v.x_ov) chk_payload(nm, v.x_ctrl, v.x_rd1, v.x_rs, v.x_rt);
    end

    // Async reset with main and skid both full.
    step("rst fill0", 0, 1, 0, C_ADDI, 32'h71, 1, 2, 1'b1);
    step("rst fill1", 0, 1, 0, C_ADDI, 32'h72, 1, 2, 1'b1);
    chk("rst pre out_valid", bus.out_valid, 1'b1);
    chk("rst pre in_ready", bus.in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst mid out_valid", bus.out_valid, 1'b0);
    chk("rst mid in_ready", bus.in_ready, 1'b1);
    chk("rst mid bubble_cnt", bubble_cnt, 2'd0);
    drive(0, 0, 1, 8'h00, 32'h0, 5'd0, 5'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst post out_valid", bus.out_valid, 1'b0);

    // Five load-use hazards against a 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      logic [1:0] xc;
      xc = (i + 1 > 3) ? 2'd3 : 2'(i + 1);
      step($sformatf("sat%0d lw", i), 0, 1, 1, C_LW, 32'h100 + i, 1, 5, 1'b1);
      chk($sformatf("sat%0d lw valid", i), bus.out_valid, 1'b1);
      chk_payload($sformatf("sat%0d lw", i), C_LW, 32'h100 + i, 5'd1, 5'd5);
      step($sformatf("sat%0d stall", i), 0, 1, 1, C_RT, 32'h200 + i, 5, 2, 1'b0);
      chk($sformatf("sat%0d bubble valid", i), bus.out_valid, 1'b1);
      chk_payload($sformatf("sat%0d bubble", i), 8'h00, 32'h0, 5'd0, 5'd0);
      chk($sformatf("sat%0d bubble_cnt", i), bubble_cnt, xc);
      step($sformatf("sat%0d use", i), 0, 1, 1, C_RT, 32'h200 + i, 5, 2, 1'b1);
      chk($sformatf("sat%0d use valid", i), bus.out_valid, 1'b1);
      chk_payload($sformatf("sat%0d use", i), C_RT, 32'h200 + i, 5'd5, 5'd2);
    end
    step("sat drain", 0, 0, 1, 8'h00, 32'h0, 0, 0, 1'b1);
    chk("sat drain out_valid", bus.out_valid, 1'b0);
    chk("sat final bubble_cnt", bubble_cnt, 2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
